// File: rtl/instruction_loader_if.sv
// Program-load bus between the debug unit's byte loader and instruction memory.
// The chk_err signal exists only when LOADER_CHECKSUM_EN is defined.
interface instruction_loader_if;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        wr_instruction;
    logic [31:0] data_instruction;
    logic [31:0] wr_addr;
    logic        busy;
    logic        load_done;
    logic        full_err;
    logic [31:0] word_count;
`ifdef LOADER_CHECKSUM_EN
    logic        chk_err;

    modport master (
        input  start, rx_data, rx_valid,
        output wr_instruction, data_instruction, wr_addr,
        output busy, load_done, full_err, word_count, chk_err
    );
    modport slave (
        output start, rx_data, rx_valid,
        input  wr_instruction, data_instruction, wr_addr,
        input  busy, load_done, full_err, word_count, chk_err
    );
`else
    modport master (
        input  start, rx_data, rx_valid,
        output wr_instruction, data_instruction, wr_addr,
        output busy, load_done, full_err, word_count
    );
    modport slave (
        output start, rx_data, rx_valid,
        input  wr_instruction, data_instruction, wr_addr,
        input  busy, load_done, full_err, word_count
    );
`endif
endinterface

// File: rtl/instruction_loader.sv
// Packs UART bytes (MSB first) into 32-bit words and writes them to instruction memory
// until the halt word or the last address. Define LOADER_CHECKSUM_EN for a trailing XOR check byte.
module instruction_loader #(
    parameter int unsigned DEPTH     = 32,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input logic                  clk,
    input logic                  rst,
    instruction_loader_if.master bus
);
    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
`ifdef LOADER_CHECKSUM_EN
        ,
        CHECK
`endif
    } state_t;

    localparam logic [31:0] LAST_ADDR = 32'(DEPTH - 1);

    state_t      state_reg;
    logic [1:0]  byte_cnt_reg;
    logic [23:0] asm_reg;
    logic [31:0] word_next;
    logic        take_start;
    logic        take_byte;
    logic        word_done;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  xor_reg;
`endif

    assign word_next  = {asm_reg, bus.rx_data};
    assign take_start = bus.start && (state_reg == IDLE || state_reg == DONE);
    assign take_byte  = bus.rx_valid && (state_reg == LOAD);
    assign word_done  = take_byte && (byte_cnt_reg == 2'd3);

    // word_count doubles as the next write address: both start at 0 and advance together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg            <= IDLE;
            byte_cnt_reg         <= 2'd0;
            asm_reg              <= 24'd0;
            bus.wr_instruction   <= 1'b0;
            bus.data_instruction <= 32'd0;
            bus.wr_addr          <= 32'd0;
            bus.busy             <= 1'b0;
            bus.load_done        <= 1'b0;
            bus.full_err         <= 1'b0;
            bus.word_count       <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
            xor_reg              <= 8'd0;
            bus.chk_err          <= 1'b0;
`endif
        end else begin
            bus.wr_instruction <= 1'b0;
            if (take_start) begin
                state_reg      <= LOAD;
                byte_cnt_reg   <= 2'd0;
                bus.busy       <= 1'b1;
                bus.load_done  <= 1'b0;
                bus.full_err   <= 1'b0;
                bus.word_count <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
                xor_reg        <= 8'd0;
                bus.chk_err    <= 1'b0;
`endif
            end else if (take_byte) begin
                byte_cnt_reg <= byte_cnt_reg + 2'd1;
                asm_reg      <= word_next[23:0];
`ifdef LOADER_CHECKSUM_EN
                xor_reg      <= xor_reg ^ bus.rx_data;
`endif
                if (word_done) begin
                    bus.wr_instruction   <= 1'b1;
                    bus.data_instruction <= word_next;
                    bus.wr_addr          <= bus.word_count;
                    bus.word_count       <= bus.word_count + 32'd1;
                    // Halt has priority, so a halt word at the last address is a clean finish.
                    if (word_next == HALT_WORD) begin
                        bus.busy      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        state_reg     <= CHECK;
`else
                        state_reg     <= DONE;
                        bus.load_done <= 1'b1;
`endif
                    end else if (bus.word_count == LAST_ADDR) begin
                        state_reg     <= DONE;
                        bus.busy      <= 1'b0;
                        bus.load_done <= 1'b1;
                        bus.full_err  <= 1'b1;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            else if (state_reg == CHECK && bus.rx_valid) begin
                state_reg     <= DONE;
                bus.load_done <= 1'b1;
                bus.chk_err   <= (bus.rx_data != xor_reg);
            end
`endif
        end
    end
endmodule
